// File: rtl/a5_pkg.sv
// rtl/a5_pkg.sv - shared constants and state encoding for the A5/1 keystream sequencer
`timescale 1ns/1ps
package a5_pkg;
  localparam int A5_KEYLEN   = 64;
  localparam int A5_FRAMELEN = 22;
  localparam int A5_MIX      = 100;
  localparam int A5_KS       = 228;
  localparam int A5_NREG     = 3;
  localparam int A5_SEQLEN   = A5_KEYLEN + A5_FRAMELEN;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    MIX,
    RUN,
    DONE
  } a5_state_e;
endpackage

// File: rtl/a5_keystream_ctrl_if.sv
// rtl/a5_keystream_ctrl_if.sv - host/LFSR/keystream signal bundle of the A5/1 sequencer
`timescale 1ns/1ps
interface a5_keystream_ctrl_if;
  import a5_pkg::*;

  logic                   start;
  logic [A5_KEYLEN-1:0]   key;
  logic [A5_FRAMELEN-1:0] frame;
  logic                   ready;
  logic                   clear_en;
  logic                   load_en;
  logic                   load_bit;
  logic [A5_NREG-1:0]     sync_bits;
  logic [A5_NREG-1:0]     exposed;
  logic [A5_NREG-1:0]     step_en;
  logic                   ks_bit;
  logic                   ks_valid;
  logic                   ks_ready;
  logic                   done;

  modport master (
    output start, key, frame, sync_bits, exposed, ks_ready,
    input  ready, clear_en, load_en, load_bit, step_en, ks_bit, ks_valid, done
  );

  modport slave (
    input  start, key, frame, sync_bits, exposed, ks_ready,
    output ready, clear_en, load_en, load_bit, step_en, ks_bit, ks_valid, done
  );
endinterface

// File: rtl/a5_majority.sv
// rtl/a5_majority.sv - majority vote over the three clocking bits and per-register step mask
`timescale 1ns/1ps
module a5_majority
  import a5_pkg::*;
(
  input  logic [A5_NREG-1:0] sync_bits,
  output logic [A5_NREG-1:0] step_en
);
  logic majority;

  assign majority = (sync_bits[0] & sync_bits[1]) |
                    (sync_bits[0] & sync_bits[2]) |
                    (sync_bits[1] & sync_bits[2]);

  // A register steps when its clocking bit agrees with the vote.
  assign step_en = ~(sync_bits ^ {A5_NREG{majority}});
endmodule

// File: rtl/a5_keystream_ctrl.sv
// rtl/a5_keystream_ctrl.sv - A5/1 sequencer: clear, serial key/frame load, mix, handshaked keystream
`timescale 1ns/1ps
module a5_keystream_ctrl
  import a5_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  a5_keystream_ctrl_if.slave bus
);
  localparam logic [6:0] LOAD_LAST = 7'(A5_SEQLEN - 1);
  localparam logic [6:0] MIX_LAST  = 7'(A5_MIX - 1);
  localparam logic [7:0] KS_TOTAL  = 8'(A5_KS);
  localparam logic [7:0] KS_LAST   = 8'(A5_KS - 1);

  a5_state_e            state;
  a5_state_e            state_next;
  logic [A5_SEQLEN-1:0] seq;
  logic [6:0]           load_idx;
  logic [6:0]           mix_cnt;
  logic [7:0]           issued;
  logic [7:0]           accepted;
  logic                 pending;
  logic                 out_bit;
  logic                 out_valid;
  logic [A5_NREG-1:0]   mask;
  logic                 slot_free;
  logic                 bit_taken;
  logic                 run_step;

  a5_majority u_majority (
    .sync_bits (bus.sync_bits),
    .step_en   (mask)
  );

  assign slot_free    = ~out_valid | bus.ks_ready;
  assign bit_taken    = out_valid & bus.ks_ready;
  assign bus.ks_bit   = out_bit;
  assign bus.ks_valid = out_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    bus.ready    = 1'b0;
    bus.clear_en = 1'b0;
    bus.load_en  = 1'b0;
    bus.load_bit = 1'b0;
    bus.step_en  = '0;
    bus.done     = 1'b0;
    run_step     = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_next = CLEAR;
      end
      CLEAR: begin
        bus.clear_en = 1'b1;
        state_next   = LOAD;
      end
      LOAD: begin
        bus.load_en  = 1'b1;
        bus.load_bit = seq[0];
        if (load_idx == LOAD_LAST) state_next = MIX;
      end
      MIX: begin
        bus.step_en = mask;
        if (mix_cnt == MIX_LAST) state_next = RUN;
      end
      RUN: begin
        if (slot_free && (issued != KS_TOTAL)) begin
          run_step    = 1'b1;
          bus.step_en = mask;
        end
        if (bit_taken && (accepted == KS_LAST)) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pending marks a step whose result is visible on exposed but not yet captured;
  // exposed stays put while stalled because no further step is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq       <= '0;
      load_idx  <= '0;
      mix_cnt   <= '0;
      issued    <= '0;
      accepted  <= '0;
      pending   <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) seq <= {bus.frame, bus.key};
        end
        CLEAR: begin
          load_idx <= '0;
          mix_cnt  <= '0;
          issued   <= '0;
          accepted <= '0;
          pending  <= 1'b0;
        end
        LOAD: begin
          seq      <= seq >> 1;
          load_idx <= load_idx + 7'd1;
        end
        MIX: begin
          mix_cnt <= mix_cnt + 7'd1;
        end
        RUN: begin
          if (slot_free) begin
            out_valid <= pending;
            if (pending) out_bit <= ^bus.exposed;
            pending <= run_step;
          end
          if (run_step) issued <= issued + 8'd1;
          if (bit_taken) accepted <= accepted + 8'd1;
        end
        DONE: begin
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_a5_keystream_ctrl.sv
// tb/tb_a5_keystream_ctrl.sv - self-checking bench: LFSR environment plus behavioural A5/1 model
`timescale 1ns/1ps
module tb_a5_keystream_ctrl;
  import a5_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  a5_keystream_ctrl_if bus ();
  a5_keystream_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  logic [2:0] t_sync;
  logic [2:0] t_mask;
  a5_majority u_maj_lit (.sync_bits(t_sync), .step_en(t_mask));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string what, input longint got, input longint want);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", what, got, want);
    end
  endtask

  // Three LFSRs standing in for the real register file, driven only by the strobes.
  logic [18:0] r1 = '0;
  logic [21:0] r2 = '0;
  logic [22:0] r3 = '0;

  function automatic logic [18:0] sh1(input logic [18:0] r);
    return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18]};
  endfunction
  function automatic logic [21:0] sh2(input logic [21:0] r);
    return {r[20:0], r[20] ^ r[21]};
  endfunction
  function automatic logic [22:0] sh3(input logic [22:0] r);
    return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22]};
  endfunction

  always @(posedge clock) begin
    if (bus.clear_en) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else if (bus.load_en) begin
      r1 <= sh1(r1) ^ 19'(bus.load_bit);
      r2 <= sh2(r2) ^ 22'(bus.load_bit);
      r3 <= sh3(r3) ^ 23'(bus.load_bit);
    end else begin
      if (bus.step_en[0]) r1 <= sh1(r1);
      if (bus.step_en[1]) r2 <= sh2(r2);
      if (bus.step_en[2]) r3 <= sh3(r3);
    end
  end

  assign bus.sync_bits = {r3[10], r2[10], r1[8]};
  assign bus.exposed   = {r3[22], r2[21], r1[18]};

  // Reference keystream, computed the way the classic C model does it.
  bit exp_ks [A5_KS];

  function automatic int unsigned lfsr_next(input int unsigned r, input int len, input int unsigned taps);
    int unsigned fb;
    fb = int'($countones(r & taps)) % 2;
    return ((r << 1) | fb) & ((32'd1 << len) - 32'd1);
  endfunction

  task automatic build_ref(input logic [63:0] k, input logic [21:0] f);
    int unsigned rv [3];
    int unsigned taps [3];
    int len [3];
    int clkb [3];
    logic [85:0] s;
    int votes;
    int unsigned maj;
    len  = '{19, 22, 23};
    clkb = '{8, 10, 10};
    taps = '{32'h0007_2000, 32'h0030_0000, 32'h0070_0080};
    rv   = '{0, 0, 0};
    s    = {f, k};
    for (int i = 0; i < A5_SEQLEN; i++)
      for (int j = 0; j < 3; j++)
        rv[j] = lfsr_next(rv[j], len[j], taps[j]) ^ 32'(s[i]);
    for (int st = 0; st < A5_MIX + A5_KS; st++) begin
      votes = 0;
      for (int j = 0; j < 3; j++) votes += int'((rv[j] >> clkb[j]) & 32'd1);
      maj = (votes >= 2) ? 32'd1 : 32'd0;
      for (int j = 0; j < 3; j++)
        if (((rv[j] >> clkb[j]) & 32'd1) == maj) rv[j] = lfsr_next(rv[j], len[j], taps[j]);
      if (st >= A5_MIX)
        exp_ks[st - A5_MIX] = bit'(((rv[0] >> 18) ^ (rv[1] >> 21) ^ (rv[2] >> 22)) & 32'd1);
    end
  endtask

  function automatic logic [2:0] maj_mask(input logic [2:0] s);
    logic [2:0] m;
    logic up;
    up = ($countones(s) >= 2);
    for (int i = 0; i < 3; i++) m[i] = (s[i] == up);
    return m;
  endfunction

  int          rel = 0;
  int          n_bits = 0;
  int          ones = 0;
  int          done_count = 0;
  bit          active = 1'b0;
  bit          full_ready = 1'b1;
  bit          rand_ready = 1'b0;
  bit          reset_seen = 1'b0;
  bit          hold_chk = 1'b0;
  bit          held_bit = 1'b0;
  logic [85:0] seq_exp;
  logic [2:0]  mm;

  // Compare process: rel counts cycles since the start-accept cycle.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      active = 1'b0; hold_chk = 1'b0; reset_seen = 1'b1;
    end else begin
      if (reset_seen) begin
        check({bus.ready, bus.clear_en, bus.load_en, bus.load_bit, bus.step_en, bus.ks_bit, bus.ks_valid, bus.done} == 10'h200,
              "reset_state", {bus.ready, bus.clear_en, bus.load_en, bus.load_bit, bus.step_en, bus.ks_bit, bus.ks_valid, bus.done}, 10'h200);
        reset_seen = 1'b0;
      end
      check($countones({bus.clear_en, bus.load_en, |bus.step_en}) <= 1, "strobe_exclusive",
            {bus.clear_en, bus.load_en, bus.step_en}, 0);
      if (hold_chk)
        check(bus.ks_valid && (bus.ks_bit == held_bit), "stall_hold", {bus.ks_valid, bus.ks_bit}, {1'b1, held_bit});
      hold_chk = 1'b0;
      if (active) begin
        rel++;
        mm = maj_mask(bus.sync_bits);
        check(!bus.ready, "busy_ready", bus.ready, 0);
        if (rel == 1) begin
          check(bus.clear_en, "clear_pulse", bus.clear_en, 1);
        end else if (rel <= 1 + A5_SEQLEN) begin
          check(bus.load_en && (bus.load_bit == seq_exp[rel-2]), $sformatf("load_bit[%0d]", rel - 2),
                {bus.load_en, bus.load_bit}, {1'b1, seq_exp[rel-2]});
        end else if (rel <= 1 + A5_SEQLEN + A5_MIX) begin
          check(bus.step_en == mm, "mix_step", bus.step_en, mm);
        end else begin
          check((bus.step_en == 3'b000) || (bus.step_en == mm), "run_step_mask", bus.step_en, mm);
          if (bus.ks_valid && !bus.ks_ready) check(bus.step_en == 3'b000, "stall_no_step", bus.step_en, 0);
        end
        if (rel <= 189) check(!bus.ks_valid, "early_valid", bus.ks_valid, 0);
        if (full_ready && rel == 190) check(bus.ks_valid, "first_valid_189", bus.ks_valid, 1);
        if (bus.ks_valid && bus.ks_ready) begin
          check(n_bits < A5_KS, "bit_count", n_bits, A5_KS - 1);
          if (n_bits < A5_KS) begin
            check(bus.ks_bit == exp_ks[n_bits], $sformatf("ks_bit[%0d]", n_bits), bus.ks_bit, exp_ks[n_bits]);
            ones += int'(bus.ks_bit);
          end
          n_bits++;
        end
        if (bus.ks_valid && !bus.ks_ready) begin
          hold_chk = 1'b1; held_bit = bus.ks_bit;
        end
        if (bus.done) begin
          check((n_bits == A5_KS) && !bus.ks_valid, "done_after_last", n_bits, A5_KS);
          if (full_ready) check(rel == 418, "done_latency_417", rel - 1, 417);
          done_count++;
          active = 1'b0;
        end
      end else begin
        check({bus.clear_en, bus.load_en, bus.step_en, bus.ks_valid, bus.done} == 7'd0, "idle_quiet",
              {bus.clear_en, bus.load_en, bus.step_en, bus.ks_valid, bus.done}, 0);
      end
      if (bus.start && bus.ready) begin
        active = 1'b1; rel = 0; n_bits = 0; ones = 0; full_ready = !rand_ready;
        seq_exp = {bus.frame, bus.key};
        build_ref(bus.key, bus.frame);
      end
    end
  end

  initial begin
    bus.ks_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      bus.ks_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_run(input logic [63:0] k, input logic [21:0] f);
    @(posedge clock); #1;
    bus.key = k; bus.frame = f; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_count == prev && t < 3000) begin
      @(posedge clock); t++;
    end
    check(done_count != prev, "run_completes", done_count, prev + 1);
  endtask

  task automatic do_run(input logic [63:0] k, input logic [21:0] f, input bit rr);
    int prev;
    rand_ready = rr;
    prev = done_count;
    start_run(k, f);
    wait_done(prev);
    repeat (3) @(posedge clock);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  logic [2:0] lit_in  [4];
  logic [2:0] lit_out [4];
  int zeros_model;
  int t;
  int prev;

  initial begin
    bus.start = 1'b0; bus.key = '0; bus.frame = '0; t_sync = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    lit_in  = '{3'b011, 3'b100, 3'b111, 3'b000};
    lit_out = '{3'b011, 3'b011, 3'b111, 3'b111};
    for (int i = 0; i < 4; i++) begin
      t_sync = lit_in[i]; #1;
      check(t_mask == lit_out[i], $sformatf("majority_%b", lit_in[i]), t_mask, lit_out[i]);
    end

    build_ref(64'd0, 22'd0);
    zeros_model = 0;
    for (int i = 0; i < A5_KS; i++) zeros_model += int'(exp_ks[i]);
    check(zeros_model == 0, "model_zero_key", zeros_model, 0);

    do_run(64'd0, 22'd0, 1'b0);
    check(ones == 0, "zero_key_stream", ones, 0);
    do_run(64'h1223_4567_89AB_CDEF, 22'h134, 1'b0);
    do_run(64'h1223_4567_89AB_CDEF, 22'h134, 1'b1);
    do_run({$urandom, $urandom}, 22'($urandom), 1'b1);

    rand_ready = 1'b0;
    start_run({$urandom, $urandom}, 22'($urandom));
    t = 0;
    while (rel != 41 && t < 200) begin
      @(posedge clock); t++;
    end
    check(rel == 41, "reach_load_idx40", rel, 41);
    pulse_reset();

    start_run(64'h1223_4567_89AB_CDEF, 22'h134);
    t = 0;
    while (n_bits != 100 && t < 1000) begin
      @(posedge clock); t++;
    end
    check(n_bits == 100, "reach_run_bit100", n_bits, 100);
    pulse_reset();

    prev = done_count;
    @(posedge clock); #1;
    bus.key = 64'h0F0F_1234_5678_9ABC; bus.frame = 22'h2AAAA; bus.start = 1'b1;
    wait_done(prev);
    @(negedge clock);
    check(bus.ready, "restart_idle_ready", bus.ready, 1);
    @(negedge clock);
    check(bus.clear_en, "restart_clear", bus.clear_en, 1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    pulse_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL global_timeout: got 0x%0h, required 0x0", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
